string_reverse_responder: RTL and testbench

- DUT-side responder for the string stimulus stream the verification agents drive: accepts a character string one byte per beat over a valid/ready handshake, buffers it, then returns it reversed with its length on a second valid/ready stream.
- Sits between the string driver interface (input side) and the monitor interface (output side).
- Serves as the reference DUT for the small, medium and large string tests.

---
 rtl/str_pkg.sv | 20 ++
 rtl/str_lifo_mem.sv | 38 +++
 rtl/string_reverse_responder.sv | 143 ++++++++++++++
 tb/tb_string_reverse_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_pkg.sv
// Shared limits and state encoding for the string reverse responder and its checkers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package str_pkg;

    localparam int MAX_LEN_DEF = 64;  // longest string accepted without overflow
    localparam int CHAR_W_DEF  = 8;   // bits per character

    // Data value carried on the single-beat overflow response.
    localparam logic [CHAR_W_DEF-1:0] ERR_CHAR = '0;

    typedef enum logic [2:0] {
        IDLE,   // buffer empty, waiting for the first character
        RECV,   // collecting characters
        SEND,   // returning stored characters newest-first
        DROP,   // overflowed; discarding until the end of the string
        ERR     // presenting the overflow response
    } str_state_t;

endpackage

// File: rtl/str_lifo_mem.sv
// Character store: register array with one synchronous write port and one combinational read port.
// Latency: write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none, the owner decides when to write and what to read.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe
//   wr_addr  write slot
//   wr_data  character to store
//   rd_addr  read slot
//   rd_data  character at rd_addr
module str_lifo_mem
    import str_pkg::*;
#(
    parameter int   DEPTH = MAX_LEN_DEF,
    parameter int   WIDTH = CHAR_W_DEF,
    localparam int  AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Deliberately not reset: the owner never reads a slot it has not written.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/string_reverse_responder.sv
// Buffers a character string and returns it reversed, with its length, or a single error beat on overflow.
// Latency: first output beat the cycle after the last input handshake; L beats in L cycles with out_ready high.
// Backpressure: in_ready low for the whole response; output beats hold stable while out_ready is low.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last input character stream, in_last on the final character
//   out_valid/out_ready/out_data      output character stream, newest character first
//   out_last                          final beat of a response
//   out_len                           string length, constant across a response (0 on error)
//   out_err                           overflow response (single beat)
module string_reverse_responder
    import str_pkg::*;
#(
    parameter int  MAX_LEN = MAX_LEN_DEF,
    parameter int  CHAR_W  = CHAR_W_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_data,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_err
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    str_state_t        state, state_nxt;
    logic [LEN_W-1:0]  wr_cnt, wr_cnt_nxt;
    logic [LEN_W-1:0]  len, len_nxt;
    logic [AW-1:0]     rd_ptr, rd_ptr_nxt;
    logic              mem_we;
    logic [CHAR_W-1:0] rd_data;

    str_lifo_mem #(
        .DEPTH (MAX_LEN),
        .WIDTH (CHAR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
            len    <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            len    <= len_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        len_nxt    = len;
        rd_ptr_nxt = rd_ptr;
        mem_we     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_len    = '0;
        out_err    = 1'b0;

        case (state)
            IDLE, RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wr_cnt < LEN_W'(MAX_LEN)) begin
                        mem_we     = 1'b1;
                        wr_cnt_nxt = wr_cnt + LEN_W'(1);
                        if (in_last) begin
                            state_nxt  = SEND;
                            len_nxt    = wr_cnt + LEN_W'(1);
                            // Newest character sits in the slot just written.
                            rd_ptr_nxt = wr_cnt[AW-1:0];
                        end else begin
                            state_nxt  = RECV;
                        end
                    end else begin
                        // Buffer already full: this character is one too many.
                        state_nxt = in_last ? ERR : DROP;
                    end
                end
            end

            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = ERR;
                end
            end

            SEND: begin
                out_valid = 1'b1;
                out_data  = rd_data;
                out_len   = len;
                out_last  = (rd_ptr == '0);
                if (out_ready) begin
                    if (rd_ptr == '0) begin
                        state_nxt  = IDLE;
                        wr_cnt_nxt = '0;
                    end else begin
                        rd_ptr_nxt = rd_ptr - AW'(1);
                    end
                end
            end

            ERR: begin
                out_valid = 1'b1;
                out_err   = 1'b1;
                out_last  = 1'b1;
                out_data  = CHAR_W'(ERR_CHAR);
                if (out_ready) begin
                    state_nxt  = IDLE;
                    wr_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt  = IDLE;
                wr_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_string_reverse_responder.sv
// Bench for string_reverse_responder: vector table, hand-written corner sequences and random strings.
// Expected responses come from a queue-reversal model of the string rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_string_reverse_responder;
    import str_pkg::*;

    localparam int ML = MAX_LEN_DEF;
    localparam int CW = CHAR_W_DEF;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [CW-1:0] in_data;
    logic          out_valid, out_ready, out_last, out_err;
    logic [CW-1:0] out_data;
    logic [LW-1:0] out_len;

    always #5 clk = ~clk;

    string_reverse_responder #(
        .MAX_LEN (ML),
        .CHAR_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_len   (out_len),
        .out_err   (out_err)
    );

    int passed = 0;
    int total  = 0;

    logic [CW-1:0] tx_q[$];
    logic [CW-1:0] rx_data[$];
    bit            rx_last[$];
    int            rx_len[$];
    bit            rx_err[$];
    int            stall_cnt;
    int            hold_bad;
    int            inrdy_bad;
    bit            got_last;

    typedef struct {
        int            n;
        logic [CW-1:0] first;
        int            pat;
        int            exp_beats;
        int            exp_len;
        bit            exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One input beat, starting and ending on a falling edge.
    task automatic push(input logic [CW-1:0] d, input bit last, input bit gap);
        int w;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = CW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        stall_cnt += w;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_all(input bit gaps);
        for (int i = 0; i < tx_q.size(); i++)
            push(tx_q[i], i == tx_q.size() - 1, gaps && ($urandom_range(0, 3) == 0));
    endtask

    // pat 0: always ready; 1: ready every third cycle (1,0,0,...); 2: random ready plus junk input.
    task automatic collect(input int pat);
        bit               stalled;
        bit               rdy;
        logic [CW+LW+1:0] saved, cur;
        rx_data.delete(); rx_last.delete(); rx_len.delete(); rx_err.delete();
        hold_bad  = 0;
        inrdy_bad = 0;
        got_last  = 1'b0;
        stalled   = 1'b0;
        saved     = '0;
        for (int cyc = 0; cyc < 400 && !got_last; cyc++) begin
            case (pat)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (pat == 2) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = CW'($urandom);
                in_last  = 1'($urandom_range(0, 1));
            end
            cur = {out_data, out_last, out_len, out_err};
            if (out_valid) begin
                if (in_ready) inrdy_bad++;
                if (stalled && cur !== saved) hold_bad++;
                if (rdy) begin
                    rx_data.push_back(out_data);
                    rx_last.push_back(out_last);
                    rx_len.push_back(int'(out_len));
                    rx_err.push_back(out_err);
                    stalled = 1'b0;
                    if (out_last) got_last = 1'b1;
                end else begin
                    stalled = 1'b1;
                    saved   = cur;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    // Reference: a string that fits comes back reversed with its length; anything longer
    // becomes one error beat with zero data and zero length.
    task automatic check_response(input string label);
        logic [CW-1:0] exp_q[$];
        int            n;
        bit            err;
        n   = tx_q.size();
        err = (n > ML);
        chk({label, " done"}, got_last, 1);
        chk({label, " in_ready low while responding"}, inrdy_bad, 0);
        chk({label, " hold during stall"}, hold_bad, 0);
        chk({label, " in_ready after"}, in_ready, 1);
        chk({label, " out_valid after"}, out_valid, 0);
        if (err) exp_q.push_back('0);
        else for (int i = n - 1; i >= 0; i--) exp_q.push_back(tx_q[i]);
        chk({label, " beats"}, rx_data.size(), exp_q.size());
        for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s data[%0d]", label, i), rx_data[i], exp_q[i]);
            chk($sformatf("%s last[%0d]", label, i), rx_last[i], (i == exp_q.size() - 1));
            chk($sformatf("%s len[%0d]", label, i), rx_len[i], err ? 0 : n);
            chk($sformatf("%s err[%0d]", label, i), rx_err[i], err);
        end
    endtask

    task automatic run_string(input string label, input int pat, input bit gaps);
        stall_cnt = 0;
        send_all(gaps);
        chk({label, " input stalls"}, stall_cnt, 0);
        chk({label, " out_valid one cycle after last"}, out_valid, 1);
        collect(pat);
        check_response(label);
    endtask

    initial begin
        int vcnt;

        vecs[0] = '{3,  8'h61, 0, 3,  3,  1'b0};  // "abc"
        vecs[1] = '{1,  8'h5A, 0, 1,  1,  1'b0};  // "Z"
        vecs[2] = '{64, 8'h00, 0, 64, 64, 1'b0};  // 0x00..0x3F, exactly full
        vecs[3] = '{65, 8'h00, 0, 1,  0,  1'b1};  // one character too many
        vecs[4] = '{5,  8'h41, 1, 5,  5,  1'b0};  // stalled consumer
        vecs[5] = '{66, 8'h10, 1, 1,  0,  1'b1};  // overflow with stalled consumer

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset out_err", out_err, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_len", out_len, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            tx_q.delete();
            for (int i = 0; i < vecs[v].n; i++) tx_q.push_back(vecs[v].first + CW'(i));
            run_string($sformatf("vec%0d", v), vecs[v].pat, 1'b0);
            chk($sformatf("vec%0d table beats", v), rx_data.size(), vecs[v].exp_beats);
            if (rx_data.size() > 0) begin
                chk($sformatf("vec%0d table len", v), rx_len[0], vecs[v].exp_len);
                chk($sformatf("vec%0d table err", v), rx_err[0], vecs[v].exp_err);
            end
        end

        // "hello" against a 1,0,0 ready pattern.
        tx_q = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        run_string("hello", 1, 1'b0);
        if (rx_data.size() == 5) begin
            chk("hello first char", rx_data[0], 8'h6F);
            chk("hello final char", rx_data[4], 8'h68);
        end

        // Reset during a response, after two of five beats.
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        send_all(1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("midreset third beat pending", out_data, 8'h33);
        #2 rst = 1'b1;
        #1;
        chk("midreset out_valid async", out_valid, 0);
        chk("midreset in_ready async", in_ready, 1);
        chk("midreset out_len async", out_len, 0);
        @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        out_ready = 1'b0;
        chk("midreset no partial response", vcnt, 0);
        tx_q = '{8'h78, 8'h79};
        run_string("after reset xy", 0, 1'b0);

        // Random strings, mostly short, sometimes around the overflow boundary.
        for (int r = 0; r < 25; r++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(ML - 1, ML + 6) : $urandom_range(1, 20);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(CW'($urandom));
            run_string($sformatf("rand%0d", r), 2, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
